// File: rtl/status_detect_pkg.sv
// ---------------------------------------------------------------------------
// Package: status_detect_pkg
// Purpose: shared constants and helpers for the status priority detector.
//   - ST_* : meaning of each state code. The code is the channel index,
//            so channel 0 (error) has the highest priority.
//   - clog2_min1 : ceil(log2(value)), but never less than 1. Widths derived
//            from it stay legal for degenerate parameter values.
// Ports: none (package).
// ---------------------------------------------------------------------------
package status_detect_pkg;

    localparam int ST_ERR  = 0;
    localparam int ST_OFF  = 1;
    localparam int ST_ON   = 2;
    localparam int ST_OPEN = 3;

    // Number of bits needed to encode 0..value-1. Always returns at least 1.
    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/ch_debounce.sv
// ---------------------------------------------------------------------------
// Module: ch_debounce
// Purpose: synchronises and debounces one raw status line.
//   A two-flop synchroniser feeds a counter. The counter runs while the
//   synced level differs from the accepted (stable) level. After DEB_CYCLES
//   consecutive differing cycles, the stable level flips. Any shorter
//   excursion clears the counter and is never seen on dout.
// Parameters:
//   DEB_CYCLES : consecutive differing cycles required to accept a change (>=1)
// Ports:
//   clk   in  1  system clock
//   rst_n in  1  asynchronous active-low reset
//   din   in  1  raw asynchronous input
//   dout  out 1  debounced level
// ---------------------------------------------------------------------------
module ch_debounce
    import status_detect_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int              CNT_W   = clog2_min1(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // The counter compares against DEB_CYCLES-1 because the cycle that hits
    // the limit is itself the DEB_CYCLES-th differing cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_a <= din;
            sync_b <= sync_a;
            if (sync_b == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign dout = stable;

endmodule

// File: rtl/status_priority_detect.sv
// ---------------------------------------------------------------------------
// Module: status_priority_detect
// Purpose: N-channel status detector for the push-button/indicator path.
//   Each channel is synchronised and debounced. The lowest-index active
//   channel is then priority-encoded into a registered state. The state is
//   held while nothing is active. A one-cycle strobe marks every change of
//   state and the first detection after reset.
// Optional feature (macro STATE_DWELL_EN):
//   When defined, dwell_cnt counts the cycles spent in the current state.
//   It saturates at all-ones. When undefined, dwell_cnt is tied to 0.
// Parameters:
//   NUM_CH     : number of channels, 2..16
//   DEB_CYCLES : debounce length in cycles, >=1
//   DWELL_W    : dwell counter width
// Ports:
//   clk         in  1        system clock
//   rst_n       in  1        asynchronous active-low reset
//   status_in   in  NUM_CH   raw status lines, active high
//   state       out STATE_W  index of highest-priority active channel
//   state_valid out 1        a channel has been detected since reset
//   state_chg   out 1        pulse in the first cycle a new state is shown
//   any_active  out 1        OR of debounced channels
//   stable_vec  out NUM_CH   debounced channel levels
//   dwell_cnt   out DWELL_W  cycles in current state (STATE_DWELL_EN only)
// ---------------------------------------------------------------------------
module status_priority_detect
    import status_detect_pkg::*;
#(
    parameter  int NUM_CH     = 4,
    parameter  int DEB_CYCLES = 16,
    parameter  int DWELL_W    = 24,
    localparam int STATE_W    = clog2_min1(NUM_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CH-1:0]  status_in,
    output logic [STATE_W-1:0] state,
    output logic               state_valid,
    output logic               state_chg,
    output logic               any_active,
    output logic [NUM_CH-1:0]  stable_vec,
    output logic [DWELL_W-1:0] dwell_cnt
);

    logic [STATE_W-1:0] sel;
    logic               chg_next;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ch_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (status_in[g]),
            .dout  (stable_vec[g])
        );
    end

    assign any_active = |stable_vec;

    // Scan from the top down so the lowest active index is written last and wins.
    always_comb begin
        sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (stable_vec[i]) begin
                sel = STATE_W'(i);
            end
        end
    end

    // A load counts as a change if it is the first since reset or if the value
    // differs. Registering the strobe beside state makes both appear on the same cycle.
    assign chg_next = any_active && (!state_valid || (sel != state));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= '0;
            state_valid <= 1'b0;
            state_chg   <= 1'b0;
        end else begin
            state_chg <= chg_next;
            if (any_active) begin
                state       <= sel;
                state_valid <= 1'b1;
            end
        end
    end

`ifdef STATE_DWELL_EN
    logic [DWELL_W-1:0] dwell_q;

    // Cleared in step with state_chg, so it reads 0 on the strobe cycle.
    // It then counts up and sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q <= '0;
        end else if (chg_next || !state_valid) begin
            dwell_q <= '0;
        end else if (dwell_q != {DWELL_W{1'b1}}) begin
            dwell_q <= dwell_q + DWELL_W'(1);
        end
    end

    assign dwell_cnt = dwell_q;
`else
    assign dwell_cnt = '0;
`endif

endmodule
